// File: rtl/cache_sa_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
// Tree-PLRU: bit0 is the root, bit1 covers ways 0/1, bit2 covers ways 2/3.
package cache_sa_pkg;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return 32 - idx_w(sets) - off_w(line_words);
  endfunction

  // A clear bit sends the victim search to the lower half.
  function automatic logic [1:0] plru_victim(
    input logic [2:0] b,
    input int         ways
  );
    logic [1:0] v;
    v = 2'd0;
    if (ways == 2) begin
      v = {1'b0, b[0]};
    end else if (ways == 4) begin
      v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    end
    return v;
  endfunction

  function automatic logic [2:0] plru_update(
    input logic [2:0] b,
    input logic [1:0] w,
    input int         ways
  );
    logic [2:0] n;
    n = b;
    if (ways == 2) begin
      n[0] = ~w[0];
    end else if (ways == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end
    return n;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree-PLRU state with an access-update port and a victim query.
// Unused tree bits for narrow associativity stay at zero.
module cache_plru
  import cache_sa_pkg::*;
#(
  parameter int SETS  = 32,
  parameter int WAYS  = 2,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_en,
  input  logic [IDX_W-1:0] acc_idx,
  input  logic [WAY_W-1:0] acc_way,
  input  logic [IDX_W-1:0] q_idx,
  output logic [WAY_W-1:0] victim
);

  logic [2:0] plru_q [SETS];
  logic [2:0] plru_d [SETS];

  always_comb begin
    plru_d = plru_q;
    if (acc_en) begin
      plru_d[acc_idx] = plru_update(plru_q[acc_idx], 2'(acc_way), WAYS);
    end
  end

  always_comb begin
    victim = WAY_W'(plru_victim(plru_q[q_idx], WAYS));
  end

  always_ff @(posedge clk) begin
    if (rst) plru_q <= '{default: '0};
    else     plru_q <= plru_d;
  end

endmodule

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back, write-allocate data cache.
// Single-cycle hits; misses stall while whole lines move to/from memory.
module cache_sa_wb
  import cache_sa_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         proc_reset,
  input  logic                         proc_read,
  input  logic                         proc_write,
  input  logic [31:0]                  proc_addr,
  input  logic [31:0]                  proc_wdata,
  output logic [31:0]                  proc_rdata,
  output logic                         proc_stall,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [31-off_w(LINE_WORDS):0] mem_addr,
  output logic [32*LINE_WORDS-1:0]     mem_wdata,
  input  logic [32*LINE_WORDS-1:0]     mem_rdata,
  input  logic                         mem_ready,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(SETS, LINE_WORDS);
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int WRD_W  = OFF_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  state_t            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              retry_q, retry_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  idx;
  logic [WRD_W-1:0]  word;
  logic              active;
  logic              unused_lsb;

  assign req_tag    = proc_addr[31 -: TAG_W];
  assign idx        = proc_addr[OFF_W +: IDX_W];
  assign word       = proc_addr[2 +: WRD_W];
  assign active     = proc_read | proc_write;
  assign unused_lsb = ^proc_addr[1:0];

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  plru_vict;
  logic [WAY_W-1:0]  vict_sel;
  logic [LINE_W-1:0] rd_line;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) inv_way = WAY_W'(w);
    end
    vict_sel   = (&valid_q[idx]) ? plru_vict : inv_way;
    rd_line    = data_q[idx][hit_way];
    proc_rdata = rd_line[{word, 5'd0} +: 32];
  end

  logic plru_en;
  logic wr_hit;
  logic fill;

  cache_plru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_plru (
    .clk     (clk),
    .rst     (proc_reset),
    .acc_en  (plru_en),
    .acc_idx (idx),
    .acc_way (hit_way),
    .q_idx   (idx),
    .victim  (plru_vict)
  );

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    retry_d    = retry_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = proc_addr[31:OFF_W];
    mem_wdata  = data_q[idx][victim_q];
    plru_en    = 1'b0;
    wr_hit     = 1'b0;
    fill       = 1'b0;
    unique case (state_q)
      COMPARE: begin
        if (active && hit) begin
          plru_en = 1'b1;
          wr_hit  = proc_write;
          retry_d = 1'b0;
          if (!retry_q) hit_cnt_d = hit_cnt_q + CNT_W'(hit_cnt_q != '1);
        end else if (active) begin
          proc_stall = 1'b1;
          retry_d    = 1'b1;
          victim_d   = vict_sel;
          miss_cnt_d = miss_cnt_q + CNT_W'(miss_cnt_q != '1);
          if (valid_q[idx][vict_sel] && dirty_q[idx][vict_sel])
            state_d = WRITEBACK;
          else
            state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall = active;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx][victim_q], idx};
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = active;
        mem_read   = 1'b1;
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q    <= COMPARE;
      victim_q   <= '0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      if (wr_hit) dirty_q[idx][hit_way] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity alone guards them.
  always_ff @(posedge clk) begin
    if (!proc_reset && fill) begin
      tag_q[idx][victim_q]  <= req_tag;
      data_q[idx][victim_q] <= mem_rdata;
    end else if (!proc_reset && wr_hit) begin
      data_q[idx][hit_way][{word, 5'd0} +: 32] <= proc_wdata;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed bench for cache_sa_wb: read data scored through an expect queue,
// memory modelled as a line store with a programmable ready latency.
module tb_cache_sa_wb;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [31:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [26:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic [3:0]   hit_count;
  logic [3:0]   miss_count;

  cache_sa_wb #(
    .SETS       (32),
    .WAYS       (2),
    .LINE_WORDS (8),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_q [$];
  logic [255:0] mem_m [logic [26:0]];

  int           rd_n = 0;
  int           wb_n = 0;
  logic [26:0]  rd_addr = '0;
  logic [26:0]  wb_addr = '0;
  logic [255:0] wb_data = '0;
  bit           hold_bad = 1'b0;
  int           max_wait = 0;
  int           cyc = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Untouched lines hold {line+0xA5A3, word index} in each word.
  function automatic logic [255:0] line_of(input logic [26:0] la);
    logic [255:0] l;
    if (mem_m.exists(la)) return mem_m[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = {16'(la[15:0] + 16'hA5A3), 16'(k)};
    return l;
  endfunction

  always @(negedge clk) begin
    if (!proc_reset && proc_read && !proc_write && !proc_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected got=%h", proc_rdata);
      end else begin
        chk("rdata", {32'd0, proc_rdata}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic access(input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp,
                        input int lat);
    int          wcnt;
    bit          done;
    logic [26:0] h_addr;
    logic        h_rd;
    wcnt = 0;
    done = 1'b0;
    cyc = 0;
    hold_bad = 1'b0;
    max_wait = 0;
    h_addr = '0;
    h_rd = 1'b0;
    if (!wr) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    proc_read  = !wr;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      if (!proc_stall) begin
        done = 1'b1;
        break;
      end
      if (mem_read || mem_write) begin
        wcnt++;
        if (wcnt > max_wait) max_wait = wcnt;
        if (wcnt == 1) begin
          h_addr = mem_addr;
          h_rd = mem_read;
        end else if (mem_addr !== h_addr || mem_read !== h_rd || proc_stall !== 1'b1) begin
          hold_bad = 1'b1;
        end
        if (wcnt >= lat) begin
          if (mem_write) begin
            mem_m[mem_addr] = mem_wdata;
            wb_n++;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
          end else begin
            rd_n++;
            rd_addr = mem_addr;
            mem_rdata = line_of(mem_addr);
          end
          mem_ready = 1'b1;
          wcnt = 0;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h got=stalled want=done", a);
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rd0;
    int wb0;
    int k;

    do_reset();
    chk("rst_stall", {63'd0, proc_stall}, 64'd0);
    chk("rst_mrd", {63'd0, mem_read}, 64'd0);
    chk("rst_mwr", {63'd0, mem_write}, 64'd0);
    chk("rst_hits", {60'd0, hit_count}, 64'd0);
    chk("rst_miss", {60'd0, miss_count}, 64'd0);
    #1 proc_reset = 1'b0;

    access(1'b0, 32'h0000_0040, '0, 32'hA5A5_0000, 1);
    chk("fill_addr", {37'd0, rd_addr}, 64'h2);
    chk("fill_cyc", 64'(cyc), 64'd3);
    chk("miss1", {60'd0, miss_count}, 64'd1);
    chk("hit0", {60'd0, hit_count}, 64'd0);

    rd0 = rd_n;
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, '0, 1);
    chk("wr_cyc", 64'(cyc), 64'd1);
    chk("wr_nomem", 64'(rd_n), 64'(rd0));
    chk("wr_hits", {60'd0, hit_count}, 64'd1);
    access(1'b0, 32'h0000_0044, '0, 32'hDEAD_BEEF, 1);
    chk("rd44_hits", {60'd0, hit_count}, 64'd2);

    wb0 = wb_n;
    access(1'b0, 32'h0000_0440, '0, 32'hA5C5_0000, 2);
    chk("f440_addr", {37'd0, rd_addr}, 64'h22);
    access(1'b0, 32'h0000_0040, '0, 32'hA5A5_0000, 1);
    chk("touch40_cyc", 64'(cyc), 64'd1);
    access(1'b0, 32'h0000_0840, '0, 32'hA5E5_0000, 1);
    chk("f840_addr", {37'd0, rd_addr}, 64'h42);
    chk("clean_nowb", 64'(wb_n), 64'(wb0));
    access(1'b0, 32'h0000_0040, '0, 32'hA5A5_0000, 1);
    chk("keep40_cyc", 64'(cyc), 64'd1);
    access(1'b0, 32'h0000_0840, '0, 32'hA5E5_0000, 1);
    chk("hit840_cyc", 64'(cyc), 64'd1);

    access(1'b0, 32'h0000_0440, '0, 32'hA5C5_0000, 3);
    chk("wb_cnt", 64'(wb_n), 64'(wb0 + 1));
    chk("wb_addr", {37'd0, wb_addr}, 64'h2);
    chk("wb_w1", {32'd0, wb_data[63:32]}, 64'hDEAD_BEEF);
    chk("wb_w0", {32'd0, wb_data[31:0]}, 64'hA5A5_0000);
    chk("wb_then_rd", {37'd0, rd_addr}, 64'h22);
    chk("cnt_hits", {60'd0, hit_count}, 64'd5);
    chk("cnt_miss", {60'd0, miss_count}, 64'd4);

    wb0 = wb_n;
    access(1'b0, 32'h0000_0044, '0, 32'hDEAD_BEEF, 20);
    chk("hold_stable", {63'd0, hold_bad}, 64'd0);
    chk("hold_wait", 64'(max_wait), 64'd20);
    chk("hold_addr", {37'd0, rd_addr}, 64'h2);
    chk("hold_nowb", 64'(wb_n), 64'(wb0));

    access(1'b1, 32'h0000_0048, 32'h1234_5678, '0, 1);
    access(1'b0, 32'h0000_0440, '0, 32'hA5C5_0000, 1);
    @(posedge clk);
    #1;
    proc_read = 1'b1;
    proc_addr = 32'h0000_0C40;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_write && k < 50);
    chk("abort_wb", {63'd0, mem_write}, 64'd1);
    chk("abort_addr", {37'd0, mem_addr}, 64'h2);
    @(posedge clk);
    #1;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mwr", {63'd0, mem_write}, 64'd0);
    chk("abort_mrd", {63'd0, mem_read}, 64'd0);
    chk("abort_stall", {63'd0, proc_stall}, 64'd0);
    chk("abort_hits", {60'd0, hit_count}, 64'd0);
    #1 proc_reset = 1'b0;

    access(1'b0, 32'h0000_0040, '0, 32'hA5A5_0000, 1);
    chk("post_miss_cyc", 64'(cyc), 64'd3);
    chk("post_miss", {60'd0, miss_count}, 64'd1);
    access(1'b0, 32'h0000_0048, '0, 32'hA5A5_0002, 1);

    for (int i = 0; i < 20; i++) begin
      access(1'b0, 32'h0000_0040, '0, 32'hA5A5_0000, 1);
    end
    chk("sat_hits", {60'd0, hit_count}, 64'hF);
    chk("sat_miss", {60'd0, miss_count}, 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
